led_output_stage: RTL and testbench
===================================

// Module: led_output_stage
// PURPOSE
//  Downstream stage of the reconfigurable shifter partition: consumes its 4-bit upper/lower outputs and drives 8 board LEDs.
//  Filters glitches, freezes LEDs during DFX reconfiguration (decouple handshake with the DFX controller), applies PWM brightness.
//  Sits in the static region; the only consumer of the RP shift outputs.
// PARAMETERS
//  HALF_W      4    width of each RP output half (upper/lower); LED width = 2*HALF_W
//  STABLE_CYC  16   consecutive equal samples required before a new RP value is committed (>=2)
//  PWM_BITS    8    PWM counter / brightness width
// PORTS
//  gclk          in   1           single clock, all logic rising-edge
//  rst_n         in   1           asynchronous, active-low reset
//  rp_upper      in   HALF_W      upper half from RP (untrusted during reconfig)
//  rp_lower      in   HALF_W      lower half from RP
//  decouple_req  in   1           level from DFX controller: 1 = RP about to be / being reconfigured
//  decouple_ack  out  1           1 = stage is frozen, RP outputs ignored
//  brightness    in   PWM_BITS    duty setting; 0 = off, all-ones = fully on
//  led           out  2*HALF_W    registered LED drive {upper,lower}
//  frozen        out  1           status: FSM not in RUN
// BEHAVIOUR
//  Reset (rst_n=0, async): led=0, decouple_ack=0, frozen=0, committed=0, cand=0, stab_cnt=0, pwm_cnt=0, bright_q=0, state=RUN.
//  Input: rp_q <= {rp_upper,rp_lower} every cycle.
//  Filter (RUN only): rp_q!=cand -> cand<=rp_q, stab_cnt<=0; else stab_cnt saturates at STABLE_CYC-1;
//   when rp_q==cand and stab_cnt==STABLE_CYC-1 -> committed<=cand.
//   Latency, rp input change to led change (full brightness): STABLE_CYC+3 gclk edges.
//  FSM states RUN, DRAIN, HOLD, RESUME:
//   RUN   : decouple_req=1 -> DRAIN.
//   DRAIN : 1 cycle; clear stab_cnt; -> HOLD.
//   HOLD  : decouple_ack=1; committed frozen; rp_q ignored; decouple_req=0 -> RESUME.
//   RESUME: ack stays 1; filter runs but committed NOT updated until stab_cnt reaches STABLE_CYC-1 with
//           rp_q==cand; then committed<=cand, -> RUN (ack=0 next cycle).
//           decouple_req re-asserted in RESUME -> HOLD immediately (stab_cnt cleared).
//  decouple_ack registered: rises 2 cycles after decouple_req rises (DRAIN+HOLD entry).
//  frozen = (state!=RUN), registered.
//  PWM: pwm_cnt free-running PWM_BITS wrap; bright_q<=brightness only when pwm_cnt==all-ones (glitch-free duty change).
//   on = (bright_q==all-ones) | (pwm_cnt<bright_q); led <= on ? committed : 0.
//  PWM runs in all FSM states: frozen LEDs keep last committed pattern at current duty.
//  Simultaneous rp change and decouple_req rise in RUN: FSM wins; committed not updated that cycle.
//  rst_n asserted mid-reconfig: immediate return to RUN with ack=0; controller must re-request.
//  X on rp inputs during HOLD must never reach led.
// STRUCTURE
//  led_stage_pkg: state enum (RUN/DRAIN/HOLD/RESUME, 2-bit), default HALF_W/STABLE_CYC/PWM_BITS constants.
//  Sub-module led_pwm_gen (pwm_cnt, bright_q sampling, 'on' output); filter + FSM + output reg in top.
// TESTING
//  1 Reset, brightness=8'hFF, rp={4'hA,4'h5} held -> led=8'hA5 exactly STABLE_CYC+3 edges after change; 0 before.
//  2 rp toggles every 5 cycles (STABLE_CYC=16) for 200 cycles -> led never changes; hold 16+ -> commits final value.
//  3 decouple_req=1, rp driven X/random -> ack=1 after 2 cycles, led constant; drop req, rp=8'h3C stable ->
//    ack falls STABLE_CYC+2 cycles later, led=8'h3C.
//  4 brightness=8'h40 -> led on 64 of every 256 cycles; change to 8'h80 mid-period -> new duty only after wrap.
//  5 brightness=0 -> led=0 always; 8'hFF -> led=committed continuously.
//  6 rst_n low during HOLD -> ack=0, led=0 asynchronously; req re-asserted in RESUME -> back to HOLD, ack stays 1.

Source files
------------

// File: rtl/led_stage_pkg.sv
// Shared types and default sizing for the LED output stage.
`default_nettype none

package led_stage_pkg;

  localparam int HALF_W_DEF     = 4;
  localparam int STABLE_CYC_DEF = 16;
  localparam int PWM_BITS_DEF   = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    RESUME = 2'd3
  } state_e;

  // Decoupled whenever the partition outputs are not trusted.
  function automatic logic is_acked(state_e s);
    return (s == HOLD) || (s == RESUME);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_gen.sv
// Free-running PWM with brightness sampled only at counter wrap.
`default_nettype none

module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                gclk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] brightness_i,
  output logic                on_o
);

  localparam logic [PWM_BITS-1:0] ALL_ONES = '1;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] bright_q;

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      bright_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      // Duty changes only take effect on a period boundary to avoid runt pulses.
      if (pwm_cnt_q == ALL_ONES) begin
        bright_q <= brightness_i;
      end
    end
  end

  assign on_o = (bright_q == ALL_ONES) || (pwm_cnt_q < bright_q);

endmodule

`default_nettype wire

// File: rtl/led_output_stage.sv
// Glitch filter, DFX decouple FSM and PWM-gated LED register for the shifter RP outputs.
`default_nettype none

module led_output_stage
  import led_stage_pkg::*;
#(
  parameter int HALF_W     = HALF_W_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF
) (
  input  logic                gclk,
  input  logic                rst_n,
  input  logic [HALF_W-1:0]   rp_upper,
  input  logic [HALF_W-1:0]   rp_lower,
  input  logic                decouple_req,
  output logic                decouple_ack,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [2*HALF_W-1:0] led,
  output logic                frozen
);

  localparam int                LED_W    = 2 * HALF_W;
  localparam int                CNT_W    = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  STAB_MAX = CNT_W'(STABLE_CYC - 1);

  state_e            state_q, state_d;
  logic [LED_W-1:0]  rp_q;
  logic [LED_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0]  stab_q, stab_d;
  logic [LED_W-1:0]  committed_q, committed_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              ack_q, ack_d;
  logic              frozen_q, frozen_d;

  logic              pwm_on;
  logic              filter_en;
  logic              match;
  logic              stable;

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .gclk         (gclk),
    .rst_n        (rst_n),
    .brightness_i (brightness),
    .on_o         (pwm_on)
  );

  assign match  = (rp_q == cand_q);
  assign stable = match && (stab_q == STAB_MAX);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    stab_d      = stab_q;
    committed_d = committed_q;
    filter_en   = 1'b0;

    case (state_q)
      RUN: begin
        // A decouple request wins over any pending commit in the same cycle.
        if (decouple_req) begin
          state_d = DRAIN;
        end else begin
          filter_en = 1'b1;
          if (stable) begin
            committed_d = cand_q;
          end
        end
      end
      DRAIN: begin
        stab_d  = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (!decouple_req) begin
          state_d = RESUME;
        end
      end
      RESUME: begin
        if (decouple_req) begin
          state_d = HOLD;
          stab_d  = '0;
        end else begin
          filter_en = 1'b1;
          if (stable) begin
            committed_d = cand_q;
            state_d     = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (filter_en) begin
      if (!match) begin
        cand_d = rp_q;
        stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + CNT_W'(1);
      end
    end

    led_d    = pwm_on ? committed_q : '0;
    ack_d    = is_acked(state_d);
    frozen_d = (state_d != RUN);
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rp_q        <= '0;
      cand_q      <= '0;
      stab_q      <= '0;
      committed_q <= '0;
      led_q       <= '0;
      ack_q       <= 1'b0;
      frozen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rp_q        <= {rp_upper, rp_lower};
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      committed_q <= committed_d;
      led_q       <= led_d;
      ack_q       <= ack_d;
      frozen_q    <= frozen_d;
    end
  end

  assign led          = led_q;
  assign decouple_ack = ack_q;
  assign frozen       = frozen_q;

endmodule

`default_nettype wire

// File: tb/tb_led_output_stage.sv
// Scoreboard bench for led_output_stage: directed stimulus queues timed expectations, a monitor checks them.
`default_nettype none

module tb_led_output_stage;

  localparam int S = 16;

  logic       gclk = 1'b0;
  logic       rst_n;
  logic [3:0] rp_upper, rp_lower;
  logic       decouple_req;
  logic       decouple_ack;
  logic [7:0] brightness;
  logic [7:0] led;
  logic       frozen;

  led_output_stage #(
    .HALF_W     (4),
    .STABLE_CYC (S),
    .PWM_BITS   (8)
  ) dut (
    .gclk         (gclk),
    .rst_n        (rst_n),
    .rp_upper     (rp_upper),
    .rp_lower     (rp_lower),
    .decouple_req (decouple_req),
    .decouple_ack (decouple_ack),
    .brightness   (brightness),
    .led          (led),
    .frozen       (frozen)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    int         cyc;
    int         kind;   // 0 led, 1 ack, 2 frozen
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   c_rel  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic push(input int c, input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push_range(input int c0, input int c1, input int kind, input logic [7:0] v,
                            input string nm);
    for (int c = c0; c <= c1; c++) push(c, kind, v, nm);
  endtask

  task automatic set_rp(input logic [7:0] v);
    {rp_upper, rp_lower} = v;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge gclk);
  endtask

  task automatic wait_pwm(input int p);
    do @(negedge gclk); while (((cyc - c_rel) & 255) != p);
  endtask

  always @(negedge gclk) begin : monitor
    int         i;
    logic [7:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          0:       act = led;
          1:       act = {7'd0, decouple_ack};
          default: act = {7'd0, frozen};
        endcase
        n_cmp++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d was not reached in time", sb[i].name, sb[i].cyc);
        end else if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin : stim
    int n, m, t, h, d, c0, c1, e, f, g;

    rst_n = 1'b0; brightness = 8'hFF; decouple_req = 1'b0;
    set_rp(8'h00);

    // Reset state
    @(posedge gclk); #2;
    push(cyc, 0, 8'h00, "rst_led");
    push(cyc, 1, 8'h00, "rst_ack");
    push(cyc, 2, 8'h00, "rst_frozen");
    @(negedge gclk);
    rst_n = 1'b1;
    c_rel = cyc;

    // 1: commit latency at full brightness (wait for the FF duty to load first)
    repeat (300) @(negedge gclk);
    n = cyc;
    set_rp(8'hA5);
    push_range(n + 1, n + S + 2, 0, 8'h00, "t1_led_before");
    push_range(n + S + 3, n + S + 6, 0, 8'hA5, "t1_led_after");
    push(n + 1, 1, 8'h00, "t1_ack");
    push(n + 1, 2, 8'h00, "t1_frozen");
    wait_cyc(n + S + 6);

    // 2: glitchy input never commits; final held value does
    m = cyc;
    t = m + 5 * 39;
    push_range(m + 1, t + S + 2, 0, 8'hA5, "t2_led_hold");
    push_range(t + S + 3, t + S + 8, 0, 8'h34, "t2_led_final");
    for (int i = 0; i < 40; i++) begin
      set_rp((i % 2) ? 8'h34 : 8'h12);
      if (i < 39) repeat (5) @(negedge gclk);
    end
    wait_cyc(t + S + 8);

    // 3: decouple with garbage inputs, then resume on a stable value
    h = cyc;
    decouple_req = 1'b1;
    push(h + 1, 1, 8'h00, "t3_ack_lat1");
    push(h + 1, 2, 8'h01, "t3_frozen");
    push_range(h + 2, h + 30, 1, 8'h01, "t3_ack_hold");
    push_range(h + 1, h + 30, 0, 8'h34, "t3_led_frozen");
    for (int j = 0; j < 29; j++) begin
      @(negedge gclk);
      set_rp(8'($urandom));
    end
    @(negedge gclk);
    d = cyc;
    decouple_req = 1'b0;
    set_rp(8'h3C);
    push_range(d + 1, d + S + 1, 1, 8'h01, "t3_ack_resume");
    push(d + S + 2, 1, 8'h00, "t3_ack_fall");
    push(d + S + 2, 2, 8'h00, "t3_frozen_fall");
    push_range(d + 1, d + S + 2, 0, 8'h34, "t3_led_old");
    push_range(d + S + 3, d + S + 5, 0, 8'h3C, "t3_led_new");
    wait_cyc(d + S + 5);

    // 4: 25% duty, then 50% requested mid-period
    wait_pwm(10);
    brightness = 8'h40;
    wait_pwm(0);
    c0 = cyc;
    for (int k = 0; k < 256; k++)
      push(c0 + 1 + k, 0, (k < 64) ? 8'h3C : 8'h00, "t4_duty40");
    for (int k = 0; k < 256; k++)
      push(c0 + 257 + k, 0, (k < 128) ? 8'h3C : 8'h00, "t4_duty80");
    wait_cyc(c0 + 128);
    brightness = 8'h80;
    wait_cyc(c0 + 512);

    // 5: off, then fully on
    wait_pwm(10);
    brightness = 8'h00;
    wait_pwm(0);
    c0 = cyc;
    push_range(c0 + 1, c0 + 256, 0, 8'h00, "t5_off");
    wait_pwm(10);
    brightness = 8'hFF;
    wait_pwm(0);
    c1 = cyc;
    push_range(c1 + 1, c1 + 256, 0, 8'h3C, "t5_full");
    wait_cyc(c1 + 256);

    // 6: async reset mid-HOLD, then re-request during RESUME
    e = cyc;
    decouple_req = 1'b1;
    push_range(e + 2, e + 5, 1, 8'h01, "t6_ack_hold");
    push_range(e + 1, e + 5, 0, 8'h3C, "t6_led_hold");
    wait_cyc(e + 5);
    @(posedge gclk); #2;
    rst_n = 1'b0;
    decouple_req = 1'b0;
    set_rp(8'h00);
    push(cyc, 0, 8'h00, "t6_async_led");
    push(cyc, 1, 8'h00, "t6_async_ack");
    push(cyc, 2, 8'h00, "t6_async_frozen");
    @(negedge gclk);
    @(negedge gclk);
    rst_n = 1'b1;
    c_rel = cyc;
    push(c_rel + 3, 1, 8'h00, "t6_ack_after_rst");
    repeat (20) @(negedge gclk);
    e = cyc;
    decouple_req = 1'b1;
    push(e + 1, 1, 8'h00, "t6_ack_lat1");
    push_range(e + 2, e + 10, 1, 8'h01, "t6_ack_hold2");
    wait_cyc(e + 10);
    f = cyc;
    decouple_req = 1'b0;
    push_range(f + 1, f + 25, 1, 8'h01, "t6_ack_rereq");
    push_range(f + 1, f + 25, 2, 8'h01, "t6_frozen_rereq");
    wait_cyc(f + 3);
    decouple_req = 1'b1;
    wait_cyc(f + 20);
    g = cyc;
    decouple_req = 1'b0;
    push(g + S, 1, 8'h01, "t6_ack_last");
    push(g + S + 1, 1, 8'h00, "t6_ack_fall");
    wait_cyc(g + S + 3);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge gclk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
